// File: rtl/rtds_tx_gate.sv
// -----------------------------------------------------------------------------
// rtds_tx_gate
//
// Store-and-forward gate for the RTDS Aurora transmit path. One complete packet
// from the VILLAS AXI-Stream source is buffered, then released downstream only
// after the receive side pulses `trigger` (one pulse per received RTDS frame),
// with a programmable trigger-to-release delay. This gives the RTDS exactly one
// reply per received frame.
//
// Ports
//   m_axis_aclk     single clock (Aurora user clock)
//   m_axis_aresetn  asynchronous active-low reset
//   s_axis_*        upstream AXI-Stream slave (tvalid/tdata/tlast/tready)
//   m_axis_*        downstream AXI-Stream master (tvalid/tdata/tlast/tready)
//   trigger         single-cycle release request
//   cfg_delay       cycles from trigger to first output word (0 = next cycle)
//   buf_armed       a complete packet is held and waiting for trigger
//   err_overflow    sticky: a packet longer than DEPTH was dropped
//   trig_miss_cnt   saturating count of triggers seen while not armed
// -----------------------------------------------------------------------------
module rtds_tx_gate #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int DELAY_WIDTH = 16
) (
    input  logic                   m_axis_aclk,
    input  logic                   m_axis_aresetn,
    input  logic                   s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                   s_axis_tlast,
    output logic                   s_axis_tready,
    output logic                   m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    input  logic                   trigger,
    input  logic [DELAY_WIDTH-1:0] cfg_delay,
    output logic                   buf_armed,
    output logic                   err_overflow,
    output logic [15:0]            trig_miss_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Length must be able to hold DEPTH itself (a full buffer).
    localparam int LW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_FILL,
        S_DISCARD,
        S_ARMED,
        S_DELAY,
        S_SEND
    } state_e;

    state_e                 state_q,   state_d;
    logic [AW-1:0]          wr_ptr_q,  wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q,  rd_ptr_d;
    logic [LW-1:0]          len_q,     len_d;
    logic [DELAY_WIDTH-1:0] dly_cnt_q, dly_cnt_d;
    logic                   err_q,     err_d;
    logic [15:0]            miss_q,    miss_d;
    // Holds s_axis_tready low while in reset and for the reset-release cycle.
    logic                   live_q;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic                   mem_we;
    logic                   last_beat;

    assign last_beat     = (LW'(rd_ptr_q) == (len_q - LW'(1)));
    assign err_overflow  = err_q;
    assign trig_miss_cnt = miss_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            state_q   <= S_FILL;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            len_q     <= '0;
            dly_cnt_q <= '0;
            err_q     <= 1'b0;
            miss_q    <= '0;
            live_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            len_q     <= len_d;
            dly_cnt_q <= dly_cnt_d;
            err_q     <= err_d;
            miss_q    <= miss_d;
            live_q    <= 1'b1;
        end
    end

    // NOTE: the packet buffer has no reset; stale contents are unreachable
    // because the pointers and length are reset.
    always_ff @(posedge m_axis_aclk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= s_axis_tdata;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can infer a latch.
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        len_d         = len_q;
        dly_cnt_d     = dly_cnt_q;
        err_d         = err_q;
        miss_d        = miss_q;
        mem_we        = 1'b0;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        buf_armed     = 1'b0;

        unique case (state_q)
            S_FILL: begin
                s_axis_tready = live_q;
                if (s_axis_tvalid && live_q) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (s_axis_tlast) begin
                        len_d   = LW'(wr_ptr_q) + LW'(1);
                        state_d = S_ARMED;
                    end else if (wr_ptr_q == AW'(DEPTH - 1)) begin
                        // Buffer full and packet still running: drop the rest.
                        err_d   = 1'b1;
                        state_d = S_DISCARD;
                    end
                end
            end

            S_DISCARD: begin
                s_axis_tready = live_q;
                if (s_axis_tvalid && live_q && s_axis_tlast) begin
                    wr_ptr_d = '0;
                    state_d  = S_FILL;
                end
            end

            S_ARMED: begin
                buf_armed = 1'b1;
                if (trigger) begin
                    if (cfg_delay == '0) begin
                        state_d = S_SEND;
                    end else begin
                        // cfg_delay is captured here only; later changes are ignored.
                        dly_cnt_d = cfg_delay;
                        state_d   = S_DELAY;
                    end
                end
            end

            S_DELAY: begin
                // Loaded with D, leaving at count 1 puts the first word at
                // trigger cycle + D + 1.
                if (dly_cnt_q == DELAY_WIDTH'(1)) begin
                    state_d = S_SEND;
                end else begin
                    dly_cnt_d = dly_cnt_q - 1'b1;
                end
            end

            S_SEND: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = mem[rd_ptr_q];
                m_axis_tlast  = last_beat;
                if (m_axis_tready) begin
                    if (last_beat) begin
                        rd_ptr_d = '0;
                        wr_ptr_d = '0;
                        state_d  = S_FILL;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
            end

            default: state_d = S_FILL;
        endcase

        // Triggers outside ARMED are dropped, never queued, only counted.
        if (trigger && (state_q != S_ARMED) && (miss_q != 16'hFFFF)) begin
            miss_d = miss_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_rtds_tx_gate.sv
// -----------------------------------------------------------------------------
// tb_rtds_tx_gate
//
// Self-checking bench for rtds_tx_gate. Expected output beats are pushed to a
// queue as input words are driven; a negedge monitor compares every valid
// output word against the queue head and pops it when the beat is accepted.
// -----------------------------------------------------------------------------
module tb_rtds_tx_gate;

    localparam int DW  = 32;
    localparam int DEP = 64;
    localparam int DLW = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           s_axis_tvalid;
    logic [DW-1:0]  s_axis_tdata;
    logic           s_axis_tlast;
    logic           s_axis_tready;
    logic           m_axis_tvalid;
    logic [DW-1:0]  m_axis_tdata;
    logic           m_axis_tlast;
    logic           m_axis_tready;
    logic           trigger;
    logic [DLW-1:0] cfg_delay;
    logic           buf_armed;
    logic           err_overflow;
    logic [15:0]    trig_miss_cnt;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks  = 0;
    int    n_errors  = 0;
    int    cyc       = 0;
    int    in_beats  = 0;
    int    out_beats = 0;

    rtds_tx_gate #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEP),
        .DELAY_WIDTH(DLW)
    ) dut (
        .m_axis_aclk   (clk),
        .m_axis_aresetn(rst_n),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .trigger       (trigger),
        .cfg_delay     (cfg_delay),
        .buf_armed     (buf_armed),
        .err_overflow  (err_overflow),
        .trig_miss_cnt (trig_miss_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output scoreboard: every valid word must match the queue head, and must
    // stay at the head (unchanged) while tready is low.
    always @(negedge clk) begin
        if (rst_n && m_axis_tvalid) begin
            if (exp_q.size() == 0) begin
                check("spurious_tvalid", 64'(m_axis_tvalid), 64'd0);
            end else begin
                check("out_tdata", 64'(m_axis_tdata), 64'(exp_q[0].data));
                check("out_tlast", 64'(m_axis_tlast), 64'(exp_q[0].last));
                if (m_axis_tready) begin
                    void'(exp_q.pop_front());
                    out_beats <= out_beats + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && s_axis_tvalid && s_axis_tready) in_beats <= in_beats + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // All tasks start and end at #1 after a rising edge.
    task automatic send_pkt(input logic [DW-1:0] base, input int n, input bit expect_out);
        for (int i = 0; i < n; i++) begin
            int w;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = base + DW'(i);
            s_axis_tlast  = (i == n - 1);
            if (expect_out) exp_q.push_back('{data: base + DW'(i), last: (i == n - 1)});
            @(negedge clk);
            w = 0;
            while (!s_axis_tready && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (!s_axis_tready) check("s_ready_timeout", 64'(s_axis_tready), 64'd1);
            @(posedge clk); #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // Pulse trigger with delay d, optionally change cfg_delay / pulse a second
    // (ignored) trigger during the delay, and check first-valid latency d+1.
    task automatic release_pkt(input int d, input int d_after, input bit poke, input string tag);
        int  t0;
        bit  seen;
        trigger   = 1'b1;
        cfg_delay = DLW'(d);
        t0        = cyc;
        @(posedge clk); #1;
        trigger   = poke;
        cfg_delay = DLW'(d_after);
        if (poke) begin
            @(posedge clk); #1;
            trigger = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < d + 20 && !seen; i++) begin
            @(negedge clk);
            if (m_axis_tvalid) seen = 1'b1;
        end
        check(tag, seen ? 64'(cyc - t0) : 64'hDEAD, 64'(d + 1));
        @(posedge clk); #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        @(posedge clk); #1;
        check({tag, "_left"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_sready"}, 64'(s_axis_tready), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sready"}, 64'(s_axis_tready), 64'd0);
        check({tag, "_mvalid"}, 64'(m_axis_tvalid), 64'd0);
        check({tag, "_mdata"},  64'(m_axis_tdata),  64'd0);
        check({tag, "_mlast"},  64'(m_axis_tlast),  64'd0);
        check({tag, "_armed"},  64'(buf_armed),     64'd0);
        check({tag, "_err"},    64'(err_overflow),  64'd0);
        check({tag, "_miss"},   64'(trig_miss_cnt), 64'd0);
    endtask

    initial begin
        int ob;
        int ib;
        rst_n         = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        trigger       = 1'b0;
        cfg_delay     = '0;

        // Reset state, then tready comes up one clock after release.
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        #1;
        check("tready_before_clk", 64'(s_axis_tready), 64'd0);
        @(posedge clk); #1;
        check("tready_after_clk", 64'(s_axis_tready), 64'd1);

        // Three triggers with no packet: counted, no output.
        repeat (3) begin
            trigger = 1'b1;
            @(posedge clk); #1;
        end
        trigger = 1'b0;
        @(posedge clk); #1;
        check("miss_three", 64'(trig_miss_cnt), 64'd3);

        // 4-word packet, delay 0.
        ob = out_beats;
        send_pkt(32'hA0, 4, 1'b1);
        check("a_armed", 64'(buf_armed), 64'd1);
        check("a_sready_low", 64'(s_axis_tready), 64'd0);
        release_pkt(0, 0, 1'b0, "a_latency");
        drain("a");
        check("a_beats", 64'(out_beats - ob), 64'd4);

        // Delay 10; cfg_delay changed and a stray trigger during DELAY.
        send_pkt(32'hB0, 2, 1'b1);
        release_pkt(10, 3, 1'b1, "b_latency");
        drain("b");
        check("b_miss", 64'(trig_miss_cnt), 64'd4);

        // tready 1,0,0,1 on a 3-word packet: words held, 3 beats total.
        ob = out_beats;
        send_pkt(32'hC0, 3, 1'b1);
        trigger = 1'b1;
        cfg_delay = '0;
        @(posedge clk); #1;
        trigger = 1'b0;
        @(posedge clk); #1;
        m_axis_tready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_axis_tready = 1'b1;
        drain("c");
        check("c_beats", 64'(out_beats - ob), 64'd3);

        // Single-word packet: tlast on the only beat.
        send_pkt(32'h5A5A_0001, 1, 1'b1);
        release_pkt(2, 2, 1'b0, "single_latency");
        drain("single");

        // Exactly DEPTH words: no overflow.
        ob = out_beats;
        send_pkt(32'h1000, DEP, 1'b1);
        check("full_armed", 64'(buf_armed), 64'd1);
        check("full_no_err", 64'(err_overflow), 64'd0);
        release_pkt(1, 1, 1'b0, "full_latency");
        drain("full");
        check("full_beats", 64'(out_beats - ob), 64'(DEP));

        // DEPTH+1 words: dropped, all accepted, sticky error; next packet works.
        ib = in_beats;
        ob = out_beats;
        send_pkt(32'h2000, DEP + 1, 1'b0);
        @(posedge clk); #1;
        check("ovf_err", 64'(err_overflow), 64'd1);
        check("ovf_not_armed", 64'(buf_armed), 64'd0);
        check("ovf_in_beats", 64'(in_beats - ib), 64'(DEP + 1));
        check("ovf_no_out", 64'(out_beats - ob), 64'd0);
        send_pkt(32'hD0, 2, 1'b1);
        check("ovf_next_armed", 64'(buf_armed), 64'd1);
        release_pkt(0, 0, 1'b0, "ovf_next_latency");
        drain("ovf_next");
        check("ovf_err_sticky", 64'(err_overflow), 64'd1);

        // Saturation of the miss counter.
        trigger = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        trigger = 1'b0;
        check("miss_saturate", 64'(trig_miss_cnt), 64'hFFFF);

        // Asynchronous reset mid-SEND, then a fresh packet.
        m_axis_tready = 1'b0;
        send_pkt(32'hE0, 4, 1'b1);
        release_pkt(0, 0, 1'b0, "e_latency");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        m_axis_tready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_sready", 64'(s_axis_tready), 64'd1);
        check("post_reset_err", 64'(err_overflow), 64'd0);
        ob = out_beats;
        send_pkt(32'hF0, 2, 1'b1);
        release_pkt(0, 0, 1'b0, "f_latency");
        drain("f");
        check("f_beats", 64'(out_beats - ob), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
